// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and helpers for the seven-segment display path.
//   SEG_OFF    : all segments dark (active-low encoding, order a..g = [6:0])
//   SEG_TABLE  : 16-entry hex glyph table, active-low, bit 6 = a ... bit 0 = g
//   idx_width  : bit width needed to hold an index/count in 0..n-1 (min 1)
// -----------------------------------------------------------------------------
package display_pkg;

    // All segments dark; segments are driven low to light.
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Glyphs 0..F as {a,b,c,d,e,f,g}, active-low. 'b' and 'd' are lower case
    // so they stay distinguishable from '8' and '0'.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Width of a register able to hold 0..n-1; never narrower than one bit so
    // single-digit or single-cycle configurations still elaborate.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational nibble to seven-segment decoder (active-low outputs).
// Ports:
//   nibble  in  [3:0]  hex digit to display
//   seg     out [6:0]  segments {a,b,c,d,e,f,g}, 0 = lit
// -----------------------------------------------------------------------------
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; every nibble code maps to a defined glyph.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/display_mux_scan.sv
// -----------------------------------------------------------------------------
// display_mux_scan
// Time-multiplexed hex seven-segment driver for NUM_DIGITS common-anode digits.
// A load strobe captures value/digit_en/dp_in into a shadow copy; the shadow is
// promoted to the displayed (active) copy only at a frame boundary so a frame
// never shows a mix of old and new data. Each digit slot lasts REFRESH_DIV
// cycles and starts with GUARD_CYCLES cycles of all anodes off to avoid
// ghosting while the segment lines change.
//
// Parameters:
//   NUM_DIGITS    digits scanned (1..8)
//   REFRESH_DIV   cycles per digit slot (>= GUARD_CYCLES+1)
//   GUARD_CYCLES  anode-off cycles at the start of each slot (0 disables)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high
//   value       in   packed nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   digit_en    in   per-digit enable (0 = blank), captured with value
//   dp_in       in   per-digit decimal point (1 = lit), captured with value
//   load        in   one-cycle capture strobe
//   an          out  anodes, active-low
//   a..g        out  segments, active-low
//   dp          out  decimal point, active-low
//   frame_done  out  one-cycle pulse with the last pin update of a frame
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, zero digits above the most significant
//                          non-zero enabled digit are blanked (digit 0 never is).
// -----------------------------------------------------------------------------
module display_mux_scan
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      a,
    output logic                      b,
    output logic                      c,
    output logic                      d,
    output logic                      e,
    output logic                      f,
    output logic                      g,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = idx_width(REFRESH_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);

    // Scan position
    logic [CNT_W-1:0]          cnt_r;
    logic [IDX_W-1:0]          idx_r;

    // Shadow (written by load) and active (being displayed) copies
    logic [4*NUM_DIGITS-1:0]   shadow_value_r;
    logic [NUM_DIGITS-1:0]     shadow_en_r;
    logic [NUM_DIGITS-1:0]     shadow_dp_r;
    logic [4*NUM_DIGITS-1:0]   active_value_r;
    logic [NUM_DIGITS-1:0]     active_en_r;
    logic [NUM_DIGITS-1:0]     active_dp_r;

    // Combinational view of the current slot
    logic                      boundary_s;
    logic                      guard_s;
    logic [3:0]                sel_nibble_s;
    logic                      sel_en_s;
    logic                      sel_dp_s;
    logic                      sel_lz_s;
    logic [NUM_DIGITS-1:0]     lz_mask_s;
    logic [6:0]                seg_dec_s;

    // Next pin values and their registers
    logic [NUM_DIGITS-1:0]     an_nx_s;
    logic [6:0]                seg_nx_s;
    logic                      dp_nx_s;
    logic [NUM_DIGITS-1:0]     an_r;
    logic [6:0]                seg_r;
    logic                      dp_r;
    logic                      frame_done_r;

    // Last cycle of the last digit's slot: the only place new data is promoted.
    always_comb begin
        boundary_s = (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);
    end

    // Anodes stay dark for the first GUARD_CYCLES cycles of every slot.
    always_comb begin
        guard_s = (cnt_r < GUARD_END);
    end

    // Slot counter and digit index; the index advances when the counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
            idx_r <= idx_r;
        end
    end

    // Shadow copy: holds the most recent load until the next frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_value_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_en_r    <= {NUM_DIGITS{1'b0}};
            shadow_dp_r    <= {NUM_DIGITS{1'b0}};
        end else if (load) begin
            shadow_value_r <= value;
            shadow_en_r    <= digit_en;
            shadow_dp_r    <= dp_in;
        end else begin
            shadow_value_r <= shadow_value_r;
            shadow_en_r    <= shadow_en_r;
            shadow_dp_r    <= shadow_dp_r;
        end
    end

    // Active copy: promoted at the frame boundary. A load landing on the
    // boundary cycle bypasses the shadow so the very next frame shows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_value_r <= {(4*NUM_DIGITS){1'b0}};
            active_en_r    <= {NUM_DIGITS{1'b0}};
            active_dp_r    <= {NUM_DIGITS{1'b0}};
        end else if (boundary_s && load) begin
            active_value_r <= value;
            active_en_r    <= digit_en;
            active_dp_r    <= dp_in;
        end else if (boundary_s) begin
            active_value_r <= shadow_value_r;
            active_en_r    <= shadow_en_r;
            active_dp_r    <= shadow_dp_r;
        end else begin
            active_value_r <= active_value_r;
            active_en_r    <= active_en_r;
            active_dp_r    <= active_dp_r;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down: a digit is suppressed while
    // it is zero and everything above it was zero or disabled. Digit 0 is
    // excluded so a zero value still shows one "0".
    always_comb begin
        logic higher_zero_v;
        higher_zero_v = 1'b1;
        lz_mask_s     = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_mask_s[i]  = higher_zero_v && (active_value_r[4*i +: 4] == 4'h0);
            higher_zero_v = higher_zero_v &&
                            ((active_value_r[4*i +: 4] == 4'h0) || !active_en_r[i]);
        end
    end
`else
    // Leading zeros are displayed like any other digit.
    always_comb begin
        lz_mask_s = {NUM_DIGITS{1'b0}};
    end
`endif

    // Select the current digit's nibble and flags from the active copy.
    // Written as an OR of one-hot terms so non-power-of-two digit counts
    // never index past the packed vectors.
    always_comb begin
        sel_nibble_s = 4'h0;
        sel_en_s     = 1'b0;
        sel_dp_s     = 1'b0;
        sel_lz_s     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_nibble_s = sel_nibble_s |
                           ((idx_r == IDX_W'(i)) ? active_value_r[4*i +: 4] : 4'h0);
            sel_en_s     = sel_en_s | ((idx_r == IDX_W'(i)) && active_en_r[i]);
            sel_dp_s     = sel_dp_s | ((idx_r == IDX_W'(i)) && active_dp_r[i]);
            sel_lz_s     = sel_lz_s | ((idx_r == IDX_W'(i)) && lz_mask_s[i]);
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (sel_nibble_s),
        .seg    (seg_dec_s)
    );

    // Next pin values: dark during guard; otherwise strobe the anode even for
    // a blanked digit so the duty cycle of every position stays identical.
    always_comb begin
        an_nx_s  = {NUM_DIGITS{1'b1}};
        seg_nx_s = SEG_OFF;
        dp_nx_s  = 1'b1;
        if (guard_s) begin
            an_nx_s  = {NUM_DIGITS{1'b1}};
            seg_nx_s = SEG_OFF;
            dp_nx_s  = 1'b1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_nx_s[i] = !(idx_r == IDX_W'(i));
            end
            if (sel_en_s && !sel_lz_s) begin
                seg_nx_s = seg_dec_s;
                dp_nx_s  = !sel_dp_s;
            end else begin
                seg_nx_s = SEG_OFF;
                dp_nx_s  = 1'b1;
            end
        end
    end

    // Pin registers; frame_done is registered alongside so it coincides with
    // the final pin update of the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r         <= {NUM_DIGITS{1'b1}};
            seg_r        <= SEG_OFF;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_nx_s;
            seg_r        <= seg_nx_s;
            dp_r         <= dp_nx_s;
            frame_done_r <= boundary_s;
        end
    end

    assign an                  = an_r;
    assign {a, b, c, d, e, f, g} = seg_r;
    assign dp                  = dp_r;
    assign frame_done          = frame_done_r;

endmodule
